lsu_wb_stage: RTL and testbench
===============================

// Module: lsu_wb_stage
// PURPOSE
//  Memory-access + writeback stage directly upstream of the register file write port.
//  Accepts one executed instruction at a time from EXU (valid/ready).
//  Performs load/store over a simple req/rsp memory port, then drives reg_wen/rd/reg_in.
//  Also emits a one-cycle commit pulse per retired instruction for difftest.
// PARAMETERS
//  XLEN      64   data/register width (matches `RegBus)
//  AW        64   memory address width
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       EXU presents an instruction
//  in_ready       out  1       stage can accept (high only in IDLE)
//  in_rd          in   5       destination register index
//  in_wen         in   1       instruction writes rd
//  in_is_load     in   1       load instruction
//  in_is_store    in   1       store instruction (never both with load)
//  in_funct3      in   3       access size/sign (RV64 LB..LWU / SB..SD encoding)
//  in_result      in   XLEN    ALU result; also the memory address for load/store
//  in_store_data  in   XLEN    rs2 value for stores
//  mem_req_valid  out  1       memory request valid
//  mem_req_ready  in   1       memory accepts request
//  mem_req_we     out  1       1=store, 0=load
//  mem_req_addr   out  AW      address, aligned down to 8 bytes
//  mem_req_wdata  out  XLEN    store data shifted to byte lane
//  mem_req_wmask  out  8       byte-enable mask
//  mem_rsp_valid  in   1       response (load data or store ack)
//  mem_rsp_rdata  in   XLEN    raw 8-byte-aligned read data
//  reg_wen        out  1       register file write enable
//  reg_rd         out  5       register file write index
//  reg_wdata      out  XLEN    register file write data
//  commit         out  1       one-cycle pulse per retired instruction
//  misalign       out  1       one-cycle pulse: misaligned access dropped
// BEHAVIOUR
//  Reset: state=IDLE; mem_req_valid, reg_wen, commit, misalign = 0; rd/data regs = 0.
//  FSM IDLE -> REQ -> RESP -> WB -> IDLE; handshake fires on in_valid&&in_ready.
//   IDLE: capture inputs on fire. ALU op -> WB. Load/store aligned -> REQ.
//         Misaligned (addr[n:0]!=0 for size 2^n) -> misalign pulse + commit, no mem, no write, stay IDLE.
//   REQ : mem_req_valid=1; payload stable until mem_req_ready; on ready -> RESP.
//   RESP: wait mem_rsp_valid. Load: latch extracted data -> WB. Store: -> WB with write suppressed.
//   WB  : reg_wen/reg_rd/reg_wdata and commit asserted exactly one cycle; -> IDLE.
//  Latency (fire at cycle N): ALU op writes at N+1; load with ready=1, rsp at N+2 writes at N+3.
//  reg_wen = captured wen && !store && rd!=0; rd==0 never writes (no reliance on regfile guard).
//  Load extract: rdata >> (addr[2:0]*8), then sign- (LB/LH/LW) or zero- (LBU/LHU/LWU) extend; LD whole word.
//  Store: wmask = {1,3,15,255}[size] << addr[2:0]; wdata = store_data << (addr[2:0]*8).
//  mem_rsp_valid outside RESP is ignored (covers stale response after reset mid-access).
//  Reset in any state: next cycle IDLE, outstanding request abandoned, no write, no commit.
//  in_ready=0 in REQ/RESP/WB; accepts new instruction in the cycle after WB at earliest.
// STRUCTURE
//  Shared package (vsrc/defines.v): `RegBus, funct3 size/sign codes, FSM state encodings.
//  Sub-module lsu_align: combinational load extract/extend + store mask/shift, reused by tests.
//  Top: FSM, input capture regs, writeback output regs.
// TESTING
//  ADD rd=5 result=0x1234 -> reg_wen=1, reg_rd=5, reg_wdata=0x1234 one cycle after fire, commit=1.
//  LB addr=0x...03, rdata=0x0000_0000_8000_0000 -> byte 0x80 -> reg_wdata=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
//  SH addr=0x...06 data=0xBEEF -> wmask=0xC0, wdata=0xBEEF<<48, we=1; no reg_wen, commit=1.
//  mem_req_ready low 4 cycles -> req held, payload stable; in_ready=0 throughout.
//  LW addr=0x...02 -> misalign pulse, no mem_req_valid, no reg_wen; in_ready stays 1.
//  rst asserted in RESP, rsp_valid next cycle -> IDLE, reg_wen=0, commit=0; load rd=0 -> no write.

Source files
------------

// File: rtl/lsu_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_wb_stage_pkg
//  Brief    : Shared widths, access-size codes and FSM encodings for the LSU/WB stage.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_wb_stage_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 64;

    // funct3[1:0] selects access size; funct3[2] marks a zero-extending load
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] addr_lo);
        logic [2:0] low_mask;
        case (funct3[1:0])
            SZ_B:    low_mask = 3'b000;
            SZ_H:    low_mask = 3'b001;
            SZ_W:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        return |(addr_lo & low_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_exu_if / lsu_mem_if
//  Brief    : EXU issue handshake and simple req/rsp memory port of the LSU/WB stage.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_exu_if;
    import lsu_wb_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            in_is_load;
    logic            in_is_store;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_store_data;

    modport master (output in_valid, in_rd, in_wen, in_is_load, in_is_store,
                           in_funct3, in_result, in_store_data,
                    input  in_ready);
    modport slave  (input  in_valid, in_rd, in_wen, in_is_load, in_is_store,
                           in_funct3, in_result, in_store_data,
                    output in_ready);
endinterface

interface lsu_mem_if;
    import lsu_wb_stage_pkg::*;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [AW-1:0]   mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    modport master (output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata);
    modport slave  (input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata);
endinterface
`default_nettype wire

// File: rtl/lsu_wb_stage_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_wb_stage_align
//  Brief    : Combinational load extract/extend and store byte-lane mask/shift.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_wb_stage_align
    import lsu_wb_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_wdata,
    output logic [7:0]      store_wmask
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic            w_signed;

    assign w_shamt     = {addr_lo, 3'b000};
    assign w_shifted   = rdata >> w_shamt;
    assign w_signed    = ~funct3[2];
    assign store_wdata = store_data << w_shamt;

    always_comb begin
        load_data   = w_shifted;
        store_wmask = 8'hFF << addr_lo;
        case (funct3[1:0])
            SZ_B: begin
                load_data   = {{(XLEN-8){w_signed & w_shifted[7]}}, w_shifted[7:0]};
                store_wmask = 8'h01 << addr_lo;
            end
            SZ_H: begin
                load_data   = {{(XLEN-16){w_signed & w_shifted[15]}}, w_shifted[15:0]};
                store_wmask = 8'h03 << addr_lo;
            end
            SZ_W: begin
                load_data   = {{(XLEN-32){w_signed & w_shifted[31]}}, w_shifted[31:0]};
                store_wmask = 8'h0F << addr_lo;
            end
            default: begin
                load_data   = w_shifted;
                store_wmask = 8'hFF << addr_lo;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_wb_stage
//  Brief    : Memory-access + writeback stage feeding the register file write port.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_wb_stage
    import lsu_wb_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    lsu_exu_if.slave        exu,
    lsu_mem_if.master       mem,
    output logic            reg_wen,
    output logic [4:0]      reg_rd,
    output logic [XLEN-1:0] reg_wdata,
    output logic            commit,
    output logic            misalign
);

    logic [1:0]      state_q,     state_d;
    logic [4:0]      rd_q,        rd_d;
    logic            wen_q,       wen_d;
    logic            is_load_q,   is_load_d;
    logic            is_store_q,  is_store_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [XLEN-1:0] sdata_q,     sdata_d;
    logic            reg_wen_q,   reg_wen_d;
    logic [4:0]      reg_rd_q,    reg_rd_d;
    logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;
    logic            commit_q,    commit_d;
    logic            misalign_q,  misalign_d;

    logic            w_fire;
    logic            w_in_mem;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_store_wdata;
    logic [7:0]      w_store_wmask;

    // Lane logic works only from captured state, so the request payload is stable in REQ
    lsu_wb_stage_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[2:0]),
        .rdata       (mem.mem_rsp_rdata),
        .store_data  (sdata_q),
        .load_data   (w_load_data),
        .store_wdata (w_store_wdata),
        .store_wmask (w_store_wmask)
    );

    assign exu.in_ready      = (state_q == ST_IDLE);
    assign w_fire            = exu.in_valid && exu.in_ready;
    assign w_in_mem          = exu.in_is_load || exu.in_is_store;

    assign mem.mem_req_valid = (state_q == ST_REQ);
    assign mem.mem_req_we    = is_store_q;
    assign mem.mem_req_addr  = {addr_q[AW-1:3], 3'b000};
    assign mem.mem_req_wdata = w_store_wdata;
    assign mem.mem_req_wmask = w_store_wmask;

    assign reg_wen   = reg_wen_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wdata = reg_wdata_q;
    assign commit    = commit_q;
    assign misalign  = misalign_q;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wen_d       = wen_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        reg_wen_d   = 1'b0;
        reg_rd_d    = reg_rd_q;
        reg_wdata_d = reg_wdata_q;
        commit_d    = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    rd_d       = exu.in_rd;
                    wen_d      = exu.in_wen;
                    is_load_d  = exu.in_is_load;
                    is_store_d = exu.in_is_store;
                    funct3_d   = exu.in_funct3;
                    addr_d     = exu.in_result[AW-1:0];
                    sdata_d    = exu.in_store_data;
                    if (!w_in_mem) begin
                        state_d     = ST_WB;
                        reg_wen_d   = exu.in_wen && (exu.in_rd != 5'd0);
                        reg_rd_d    = exu.in_rd;
                        reg_wdata_d = exu.in_result;
                        commit_d    = 1'b1;
                    end else if (is_misaligned(exu.in_funct3, exu.in_result[2:0])) begin
                        misalign_d = 1'b1;
                        commit_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) state_d = ST_REQ + 2'd1;
            end
            ST_RESP: begin
                if (mem.mem_rsp_valid) begin
                    state_d   = ST_WB;
                    reg_rd_d  = rd_q;
                    commit_d  = 1'b1;
                    reg_wen_d = is_load_q && wen_q && (rd_q != 5'd0);
                    if (is_load_q) reg_wdata_d = w_load_data;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            reg_wen_q   <= 1'b0;
            reg_rd_q    <= '0;
            reg_wdata_q <= '0;
            commit_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            reg_wen_q   <= reg_wen_d;
            reg_rd_q    <= reg_rd_d;
            reg_wdata_q <= reg_wdata_d;
            commit_q    <= commit_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_wb_stage
//  Brief    : Directed self-checking bench for lsu_wb_stage with a retire scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_wb_stage;
    import lsu_wb_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_wen;
    logic [4:0]      reg_rd;
    logic [XLEN-1:0] reg_wdata;
    logic            commit;
    logic            misalign;

    always #5 clk = ~clk;

    lsu_exu_if exu_bus ();
    lsu_mem_if mem_bus ();

    lsu_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .exu       (exu_bus.slave),
        .mem       (mem_bus.master),
        .reg_wen   (reg_wen),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .commit    (commit),
        .misalign  (misalign)
    );

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] res, input logic [63:0] sdata,
                         input logic push, input exp_t e);
        chk({tag, " in_ready"}, 64'(exu_bus.in_ready), 64'd1);
        exu_bus.in_valid      = 1'b1;
        exu_bus.in_rd         = rd;
        exu_bus.in_wen        = wen;
        exu_bus.in_is_load    = ld;
        exu_bus.in_is_store   = st;
        exu_bus.in_funct3     = f3;
        exu_bus.in_result     = res;
        exu_bus.in_store_data = sdata;
        if (push) exp_q.push_back(e);
        tick();
        exu_bus.in_valid = 1'b0;
    endtask

    task automatic mem_serve(input string tag, input int delay, input logic [63:0] rdata,
                             input logic we, input logic [63:0] addr,
                             input logic [7:0] wmask, input logic [63:0] wdata);
        int n = 0;
        while (mem_bus.mem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " req_valid"}, 64'(mem_bus.mem_req_valid), 64'd1);
        chk({tag, " req_we"},    64'(mem_bus.mem_req_we),    64'(we));
        chk({tag, " req_addr"},  mem_bus.mem_req_addr,       addr);
        if (we) begin
            chk({tag, " req_wmask"}, 64'(mem_bus.mem_req_wmask), 64'(wmask));
            chk({tag, " req_wdata"}, mem_bus.mem_req_wdata,      wdata);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, " hold valid/in_ready/wmask"},
                64'({mem_bus.mem_req_valid, exu_bus.in_ready, mem_bus.mem_req_wmask}),
                64'({1'b1, 1'b0, (we ? wmask : mem_bus.mem_req_wmask)}));
            chk({tag, " hold addr^wdata"}, mem_bus.mem_req_addr ^ (we ? mem_bus.mem_req_wdata : 64'd0),
                addr ^ (we ? wdata : 64'd0));
        end
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        chk({tag, " req dropped in RESP"}, 64'({mem_bus.mem_req_valid, exu_bus.in_ready}), 64'd0);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = rdata;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic retire(input string tag, input int exp_wait);
        int   n = 0;
        exp_t e;
        while (commit !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " commit"}, 64'(commit), 64'd1);
        if (exp_wait >= 0) chk({tag, " latency"}, 64'(n), 64'(exp_wait));
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " reg_wen"},  64'(reg_wen),  64'(e.wen));
            chk({tag, " misalign"}, 64'(misalign), 64'(e.mis));
            if (e.wen) begin
                chk({tag, " reg_rd"},    64'(reg_rd), 64'(e.rd));
                chk({tag, " reg_wdata"}, reg_wdata,   e.wdata);
            end
        end
        tick();
        chk({tag, " pulse end"}, 64'({commit, reg_wen, misalign, exu_bus.in_ready}), 64'b0001);
    endtask

    initial begin
        rst                   = 1'b1;
        exu_bus.in_valid      = 1'b0;
        exu_bus.in_rd         = '0;
        exu_bus.in_wen        = 1'b0;
        exu_bus.in_is_load    = 1'b0;
        exu_bus.in_is_store   = 1'b0;
        exu_bus.in_funct3     = '0;
        exu_bus.in_result     = '0;
        exu_bus.in_store_data = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_rdata = '0;
        tick();
        tick();
        chk("reset outputs", 64'({reg_wen, commit, misalign, mem_bus.mem_req_valid}), 64'd0);
        chk("reset reg_rd", 64'(reg_rd), 64'd0);
        chk("reset reg_wdata", reg_wdata, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle in_ready", 64'(exu_bus.in_ready), 64'd1);

        // ALU op writes one cycle after fire
        issue("ADD", 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1,
              '{1'b1, 5'd5, 64'h1234, 1'b0});
        chk("ADD in_ready low in WB", 64'(exu_bus.in_ready), 64'd0);
        retire("ADD", 0);

        issue("ALU rd0", 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 64'h55AA, 64'd0, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        retire("ALU rd0", 0);

        issue("LB", 5'd10, 1'b1, 1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 1'b1,
              '{1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
        mem_serve("LB", 0, 64'h0000_0000_8000_0000, 1'b0, 64'h1000, 8'h00, 64'd0);
        retire("LB", 0);

        issue("LBU", 5'd11, 1'b1, 1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 1'b1,
              '{1'b1, 5'd11, 64'h80, 1'b0});
        mem_serve("LBU", 0, 64'h0000_0000_8000_0000, 1'b0, 64'h1000, 8'h00, 64'd0);
        retire("LBU", 0);

        issue("LH", 5'd12, 1'b1, 1'b1, 1'b0, 3'b001, 64'h2006, 64'd0, 1'b1,
              '{1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_8765, 1'b0});
        mem_serve("LH", 1, 64'h8765_4321_0000_0000, 1'b0, 64'h2000, 8'h00, 64'd0);
        retire("LH", 0);

        issue("LW", 5'd13, 1'b1, 1'b1, 1'b0, 3'b010, 64'h2004, 64'd0, 1'b1,
              '{1'b1, 5'd13, 64'hFFFF_FFFF_8765_4321, 1'b0});
        mem_serve("LW", 0, 64'h8765_4321_0000_0000, 1'b0, 64'h2000, 8'h00, 64'd0);
        retire("LW", 0);

        issue("LWU", 5'd14, 1'b1, 1'b1, 1'b0, 3'b110, 64'h2004, 64'd0, 1'b1,
              '{1'b1, 5'd14, 64'h0000_0000_8765_4321, 1'b0});
        mem_serve("LWU", 0, 64'h8765_4321_0000_0000, 1'b0, 64'h2000, 8'h00, 64'd0);
        retire("LWU", 0);

        issue("LD", 5'd15, 1'b1, 1'b1, 1'b0, 3'b011, 64'h3000, 64'd0, 1'b1,
              '{1'b1, 5'd15, 64'h0123_4567_89AB_CDEF, 1'b0});
        mem_serve("LD", 0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h3000, 8'h00, 64'd0);
        retire("LD", 0);

        issue("SH", 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 64'h4006, 64'hBEEF, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        mem_serve("SH", 0, 64'd0, 1'b1, 64'h4000, 8'hC0, 64'hBEEF_0000_0000_0000);
        retire("SH", 0);

        // Memory stalls the request for four cycles
        issue("SW", 5'd7, 1'b1, 1'b0, 1'b1, 3'b010, 64'h4004, 64'h1122_3344_5566_7788, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        mem_serve("SW", 4, 64'd0, 1'b1, 64'h4000, 8'hF0, 64'h5566_7788_0000_0000);
        retire("SW", 0);

        issue("SB", 5'd7, 1'b1, 1'b0, 1'b1, 3'b000, 64'h4001, 64'h0000_0000_0000_00AB, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        mem_serve("SB", 0, 64'd0, 1'b1, 64'h4000, 8'h02, 64'h0000_0000_0000_AB00);
        retire("SB", 0);

        issue("LW mis", 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 64'h5002, 64'd0, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b1});
        chk("LW mis no req", 64'({mem_bus.mem_req_valid, exu_bus.in_ready}), 64'b01);
        retire("LW mis", 0);

        issue("SD mis", 5'd0, 1'b0, 1'b0, 1'b1, 3'b011, 64'h5004, 64'h1, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b1});
        chk("SD mis no req", 64'({mem_bus.mem_req_valid, exu_bus.in_ready}), 64'b01);
        retire("SD mis", 0);

        issue("LD rd0", 5'd0, 1'b1, 1'b1, 1'b0, 3'b011, 64'h6000, 64'd0, 1'b1,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        mem_serve("LD rd0", 0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h6000, 8'h00, 64'd0);
        retire("LD rd0", 0);

        // Reset while waiting for a response, followed by a stale response
        issue("LD rst", 5'd9, 1'b1, 1'b1, 1'b0, 3'b011, 64'h7000, 64'd0, 1'b0,
              '{1'b0, 5'd0, 64'h0, 1'b0});
        chk("LD rst req", 64'(mem_bus.mem_req_valid), 64'd1);
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        chk("rst in RESP idle", 64'({exu_bus.in_ready, mem_bus.mem_req_valid, reg_wen, commit}), 64'b1000);
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        chk("stale rsp ignored", 64'({exu_bus.in_ready, mem_bus.mem_req_valid, reg_wen, commit}), 64'b1000);
        tick();
        chk("stale rsp quiet", 64'({reg_wen, commit, misalign}), 64'd0);

        issue("ADD after rst", 5'd31, 1'b1, 1'b0, 1'b0, 3'b000, 64'hCAFE, 64'd0, 1'b1,
              '{1'b1, 5'd31, 64'hCAFE, 1'b0});
        retire("ADD after rst", 0);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
